// File: rtl/router_pkt_rx_pkg.sv
// rtl/router_pkt_rx_pkg.sv - shared types and header field layout for the router port packet receiver
package router_pkt_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_W  = 2;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
    localparam int CNT_W   = 16;

endpackage

// File: rtl/router_pkt_rx_if.sv
// rtl/router_pkt_rx_if.sv - FIFO read handshake and consumer-side packet signals of the receiver
interface router_pkt_rx_if;
    import router_pkt_rx_pkg::*;

    logic              vld_out;
    logic [7:0]        data_out;
    logic              read_enb;
    logic              rx_hold;
    logic              pl_valid;
    logic [7:0]        pl_data;
    logic              pkt_done;
    logic              pkt_err;
    logic              pkt_abort;
    logic [ADDR_W-1:0] pkt_addr;
    logic [LEN_W-1:0]  pkt_len;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        input  vld_out, data_out, rx_hold,
        output read_enb, pl_valid, pl_data, pkt_done, pkt_err, pkt_abort,
               pkt_addr, pkt_len, pkt_cnt, err_cnt
    );

    modport slave (
        output vld_out, data_out, rx_hold,
        input  read_enb, pl_valid, pl_data, pkt_done, pkt_err, pkt_abort,
               pkt_addr, pkt_len, pkt_cnt, err_cnt
    );

endinterface

// File: rtl/router_pkt_rx_stats.sv
// rtl/router_pkt_rx_stats.sv - saturating good/error packet counters, built only with ROUTER_PKT_RX_STATS_EN
`ifdef ROUTER_PKT_RX_STATS_EN
module router_pkt_rx_stats
    import router_pkt_rx_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             done_i,
    input  logic             err_i,
    input  logic             abort_i,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (done_i && !err_i && (pkt_cnt_q != '1))
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (((done_i && err_i) || abort_i) && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;

endmodule
`endif

// File: rtl/router_pkt_rx.sv
// rtl/router_pkt_rx.sv - router1x3 output-port packet receiver: header/payload/parity parse with read timeout
// Optional saturating statistics counters under ROUTER_PKT_RX_STATS_EN.
module router_pkt_rx
    import router_pkt_rx_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic         clock,
    input  logic         resetn,
    router_pkt_rx_if.master bus
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic [6:0]        rd_left_q, rd_left_d;
    logic [6:0]        cap_left_q, cap_left_d;
    logic [7:0]        par_q, par_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              pl_valid_q, pl_valid_d;
    logic [7:0]        pl_data_q, pl_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rd_req;
    logic              tmo_hit;

    // A pending read always wins over the timeout so an in-flight byte is never lost.
    assign tmo_hit = (state_q != IDLE) && !rd_pend_q && (tmo_q >= TMO_LIM);

    always_comb begin
        state_d    = state_q;
        rd_left_d  = rd_left_q;
        cap_left_d = cap_left_q;
        par_d      = par_q;
        tmo_d      = tmo_q + 8'd1;
        pl_valid_d = 1'b0;
        pl_data_d  = pl_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        abort_d    = 1'b0;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_req     = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d  = '0;
                rd_req = bus.vld_out && !bus.rx_hold && !rd_pend_q;
                if (rd_req && bus.vld_out)
                    state_d = HDR;
            end
            HDR: begin
                if (rd_pend_q) begin
                    addr_d     = bus.data_out[ADDR_W-1:0];
                    len_d      = bus.data_out[LEN_MSB:LEN_LSB];
                    par_d      = bus.data_out;
                    rd_left_d  = 7'(bus.data_out[LEN_MSB:LEN_LSB]) + 7'd1;
                    cap_left_d = 7'(bus.data_out[LEN_MSB:LEN_LSB]) + 7'd1;
                    tmo_d      = '0;
                    state_d    = BODY;
                end
            end
            BODY: begin
                rd_req = bus.vld_out && !bus.rx_hold && (rd_left_q != '0) && !tmo_hit;
                if (rd_req && bus.vld_out)
                    rd_left_d = rd_left_q - 7'd1;
                if (rd_pend_q) begin
                    tmo_d      = '0;
                    cap_left_d = cap_left_q - 7'd1;
                    if (cap_left_q > 7'd1) begin
                        par_d      = par_q ^ bus.data_out;
                        pl_valid_d = 1'b1;
                        pl_data_d  = bus.data_out;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = (bus.data_out != par_q);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            abort_d    = 1'b1;
            rd_left_d  = '0;
            cap_left_d = '0;
            tmo_d      = '0;
            state_d    = IDLE;
        end
        rd_pend_d = rd_req && bus.vld_out;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rd_pend_q  <= 1'b0;
            rd_left_q  <= '0;
            cap_left_q <= '0;
            par_q      <= '0;
            tmo_q      <= '0;
            pl_valid_q <= 1'b0;
            pl_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_left_q  <= rd_left_d;
            cap_left_q <= cap_left_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            pl_valid_q <= pl_valid_d;
            pl_data_q  <= pl_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
        end
    end

    assign bus.read_enb  = rd_req && resetn;
    assign bus.pl_valid  = pl_valid_q;
    assign bus.pl_data   = pl_data_q;
    assign bus.pkt_done  = done_q;
    assign bus.pkt_err   = err_q;
    assign bus.pkt_abort = abort_q;
    assign bus.pkt_addr  = addr_q;
    assign bus.pkt_len   = len_q;

`ifdef ROUTER_PKT_RX_STATS_EN
    router_pkt_rx_stats u_stats (
        .clock     (clock),
        .resetn    (resetn),
        .done_i    (done_q),
        .err_i     (err_q),
        .abort_i   (abort_q),
        .pkt_cnt_o (bus.pkt_cnt),
        .err_cnt_o (bus.err_cnt)
    );
`else
    assign bus.pkt_cnt = '0;
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_pkt_rx.sv
// tb/tb_router_pkt_rx.sv - scoreboard bench for router_pkt_rx with a FIFO model and packet-level reference
module tb_router_pkt_rx;
    import router_pkt_rx_pkg::*;

    localparam int TMO      = 16;
    localparam int EV_PL    = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       err;
        logic [1:0] addr;
        logic [5:0] len;
    } ev_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    router_pkt_rx_if bus();

    router_pkt_rx #(.TIMEOUT(TMO)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clock = ~clock;

    ev_t        exp_q[$];
    logic [7:0] fifo_q[$];
    bit         hdr_q[$];
    int n_vec = 0, n_mis = 0;
    int n_reads = 0, hdr_reads = 0, pkts_closed = 0;
    int exp_good = 0, exp_bad = 0;
    bit hold_force = 0, rand_en = 0, ev_hold = 0;
    int ev_cnt = 0, cool = 0;
    ev_t mon_e;
    bit  mon_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xp(input logic [7:0] h, input logic [7:0] p[$]);
        logic [7:0] r;
        r = h;
        foreach (p[i]) r ^= p[i];
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit is_hdr);
        fifo_q.push_back(b);
        hdr_q.push_back(is_hdr);
    endtask

    task automatic send_raw(input logic [7:0] hdr, input logic [7:0] pl[$], input logic [7:0] par);
        ev_t e;
        push_byte(hdr, 1'b1);
        foreach (pl[i]) begin
            push_byte(pl[i], 1'b0);
            e = '{kind: EV_PL, data: pl[i], err: 1'b0, addr: 2'd0, len: 6'd0};
            exp_q.push_back(e);
        end
        push_byte(par, 1'b0);
        e = '{kind: EV_DONE, data: 8'd0, err: (par != xp(hdr, pl)), addr: hdr[1:0], len: hdr[7:2]};
        exp_q.push_back(e);
        if (e.err) exp_bad++;
        else exp_good++;
    endtask

    // Header plus some payload, then the FIFO runs dry: only an abort may close it.
    task automatic send_partial(input logic [7:0] hdr, input logic [7:0] pl[$]);
        ev_t e;
        push_byte(hdr, 1'b1);
        foreach (pl[i]) begin
            push_byte(pl[i], 1'b0);
            e = '{kind: EV_PL, data: pl[i], err: 1'b0, addr: 2'd0, len: 6'd0};
            exp_q.push_back(e);
        end
        e = '{kind: EV_ABORT, data: 8'd0, err: 1'b0, addr: 2'd0, len: 6'd0};
        exp_q.push_back(e);
        exp_bad++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain_timeout: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic take(input int kind);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_event: got kind %0d required none", kind);
            mon_ok = 1'b0;
        end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", kind, mon_e.kind);
            mon_ok = (mon_e.kind == kind);
        end
    endtask

    // FIFO model: pop on an accepted read, present the byte on the next cycle.
    always @(posedge clock) begin
        if (resetn && bus.read_enb && bus.vld_out && fifo_q.size() != 0) begin
            n_reads++;
            if (hdr_q[0]) begin
                check("hdr_before_close", hdr_reads, pkts_closed);
                hdr_reads++;
            end
            bus.data_out <= fifo_q.pop_front();
            void'(hdr_q.pop_front());
        end
        if (resetn && bus.rx_hold)
            check("read_during_hold", bus.read_enb, 1'b0);
    end

    always @(negedge clock) begin
        if (ev_cnt > 0) begin
            ev_cnt--;
            if (ev_cnt == 0) cool = 4;
        end else if (cool > 0) begin
            cool--;
        end else if (rand_en && $urandom_range(0, 5) == 0) begin
            ev_cnt  = $urandom_range(1, 5);
            ev_hold = ($urandom_range(0, 1) == 1);
        end
        bus.rx_hold = hold_force || (ev_cnt > 0 && ev_hold);
        bus.vld_out = (fifo_q.size() != 0) && !(ev_cnt > 0 && !ev_hold);
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (!bus.pkt_done)
                check("err_without_done", bus.pkt_err, 1'b0);
            if (bus.pl_valid) begin
                take(EV_PL);
                if (mon_ok) check("pl_data", bus.pl_data, mon_e.data);
            end
            if (bus.pkt_done) begin
                take(EV_DONE);
                if (mon_ok) begin
                    check("pkt_err", bus.pkt_err, mon_e.err);
                    check("pkt_addr", bus.pkt_addr, mon_e.addr);
                    check("pkt_len", bus.pkt_len, mon_e.len);
                end
                pkts_closed++;
            end
            if (bus.pkt_abort) begin
                take(EV_ABORT);
                pkts_closed++;
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] hdr, par;
        int r0, n, len, t;

        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_read_enb", bus.read_enb, 1'b0);
        check("rst_pl_valid", bus.pl_valid, 1'b0);
        check("rst_pl_data", bus.pl_data, 8'h00);
        check("rst_pkt_done", bus.pkt_done, 1'b0);
        check("rst_pkt_err", bus.pkt_err, 1'b0);
        check("rst_pkt_abort", bus.pkt_abort, 1'b0);
        check("rst_pkt_addr", bus.pkt_addr, 2'd0);
        check("rst_pkt_len", bus.pkt_len, 6'd0);
        check("rst_pkt_cnt", bus.pkt_cnt, 16'd0);
        check("rst_err_cnt", bus.err_cnt, 16'd0);
        resetn = 1'b1;
        @(negedge clock);

        pl = {8'h11, 8'h22, 8'h33};
        send_raw(8'h0D, pl, xp(8'h0D, pl));
        drain();
        send_raw(8'h0D, pl, 8'h00);
        drain();

        pl.delete();
        r0 = n_reads;
        send_raw(8'h02, pl, 8'h02);
        drain();
        check("len0_reads", n_reads - r0, 2);

        pl = {8'hA1, 8'hA2};
        send_raw({6'd2, 2'd3}, pl, xp({6'd2, 2'd3}, pl));
        pl = {8'h5C};
        send_raw({6'd1, 2'd0}, pl, xp({6'd1, 2'd0}, pl));
        drain();

        pl = {8'h55, 8'h66};
        send_partial({6'd4, 2'd2}, pl);
        drain();
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        send_raw({6'd4, 2'd2}, pl, xp({6'd4, 2'd2}, pl));
        drain();

        pl.delete();
        for (int b = 0; b < 8; b++) pl.push_back(8'($urandom));
        send_raw({6'd8, 2'd1}, pl, xp({6'd8, 2'd1}, pl));
        t = 0;
        while (exp_q.size() > 6 && t < 200) begin
            @(negedge clock);
            t++;
        end
        hold_force = 1'b1;
        repeat (6) @(negedge clock);
        hold_force = 1'b0;
        drain();

        rand_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                len = (k == 20 && j == 0) ? 63 : $urandom_range(0, 12);
                pl.delete();
                for (int b = 0; b < len; b++) pl.push_back(8'($urandom));
                hdr = {6'(len), 2'($urandom_range(0, 3))};
                par = xp(hdr, pl);
                if ($urandom_range(0, 3) == 0) par ^= 8'($urandom_range(1, 255));
                send_raw(hdr, pl, par);
            end
            drain();
        end
        rand_en = 1'b0;
        drain();

        check("events_left", exp_q.size(), 0);
`ifdef ROUTER_PKT_RX_STATS_EN
        check("pkt_cnt", bus.pkt_cnt, exp_good);
        check("err_cnt", bus.err_cnt, exp_bad);
`else
        check("pkt_cnt", bus.pkt_cnt, 16'd0);
        check("err_cnt", bus.err_cnt, 16'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
